// File: rtl/uart_rx_frame_dispatcher.sv
// Buffers UART receiver frames in a small FIFO and offers each one to the consumer
// selected by its opt byte; drops and counts overflow, unroutable and stalled frames.
module uart_rx_frame_dispatcher #(
   parameter int unsigned BYTE_SIZE = 8,
   parameter int unsigned DATA_SIZE = 64,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned NUM_DEST  = 4,
   parameter int unsigned TIMEOUT   = 1024,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [BYTE_SIZE-1:0] in_opt,
   input  logic [BYTE_SIZE-1:0] in_len,
   input  logic [DATA_SIZE-1:0] in_data,
   input  logic                 in_valid,
   output logic [BYTE_SIZE-1:0] o_opt,
   output logic [BYTE_SIZE-1:0] o_len,
   output logic [DATA_SIZE-1:0] o_data,
   output logic [NUM_DEST-1:0]  o_valid,
   input  logic [NUM_DEST-1:0]  i_ready,
   output logic                 o_busy,
   output logic [CNT_W-1:0]     cnt_overflow,
   output logic [CNT_W-1:0]     cnt_bad_opt,
   output logic [CNT_W-1:0]     cnt_timeout
);

   localparam int unsigned ENTRY_W = 2 * BYTE_SIZE + DATA_SIZE;
   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned OCC_W   = PTR_W + 1;
   localparam int unsigned IDX_W   = $clog2(NUM_DEST);
   localparam int unsigned TMR_W   = $clog2(TIMEOUT + 1);
   localparam int unsigned OPTX_W  = BYTE_SIZE + 1;

   localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(DEPTH);
   localparam logic [OPTX_W-1:0] OPT_LIM  = OPTX_W'(NUM_DEST);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_OFFER} state_t;

   state_t               r_state, w_state_nxt;
   logic [ENTRY_W-1:0]   r_mem [DEPTH];
   logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
   logic [OCC_W-1:0]     r_occ, w_occ_nxt;
   logic [TMR_W-1:0]     r_timer, w_timer_nxt;
   logic [BYTE_SIZE-1:0] r_opt, r_len;
   logic [DATA_SIZE-1:0] r_data;
   logic [NUM_DEST-1:0]  r_valid, w_valid_nxt;
   logic                 r_busy, w_busy_nxt;
   logic [CNT_W-1:0]     r_cnt_ovf, r_cnt_bad, r_cnt_to;
   logic                 w_full, w_push, w_pop, w_bad, w_ready;
   logic                 w_inc_ovf, w_inc_bad, w_inc_to;

   assign w_full    = (r_occ == OCC_FULL);
   assign w_push    = in_valid && !w_full;
   assign w_inc_ovf = in_valid && w_full;
   assign w_bad     = ({1'b0, r_opt} >= OPT_LIM);
   // r_valid is one-hot on the selected consumer, so this ignores all other ready bits
   assign w_ready   = |(i_ready & r_valid);

   // next-state, offer and drop decisions
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_valid_nxt = r_valid;
      w_pop       = 1'b0;
      w_inc_bad   = 1'b0;
      w_inc_to    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_occ != '0) begin
               w_pop       = 1'b1;
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_bad) begin
               w_inc_bad   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_timer_nxt = '0;
               w_valid_nxt = NUM_DEST'(1) << r_opt[IDX_W-1:0];
               w_state_nxt = S_OFFER;
            end
         end
         S_OFFER: begin
            if (w_ready) begin
               w_valid_nxt = '0;
               w_state_nxt = S_IDLE;
            end else if (r_timer == TMR_LAST) begin
               w_inc_to    = 1'b1;
               w_valid_nxt = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_timer_nxt = r_timer + TMR_W'(1);
            end
         end
         default: begin
            w_valid_nxt = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
      w_occ_nxt  = r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
      w_busy_nxt = (w_occ_nxt != '0) || (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= S_IDLE;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_occ     <= '0;
         r_timer   <= '0;
         r_opt     <= '0;
         r_len     <= '0;
         r_data    <= '0;
         r_valid   <= '0;
         r_busy    <= 1'b0;
         r_cnt_ovf <= '0;
         r_cnt_bad <= '0;
         r_cnt_to  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_occ   <= w_occ_nxt;
         r_timer <= w_timer_nxt;
         r_valid <= w_valid_nxt;
         r_busy  <= w_busy_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop) begin
            r_rd_ptr                <= r_rd_ptr + PTR_W'(1);
            {r_opt, r_len, r_data}  <= r_mem[r_rd_ptr];
         end
         // statistics saturate instead of wrapping
         if (w_inc_ovf && (r_cnt_ovf != '1)) r_cnt_ovf <= r_cnt_ovf + CNT_W'(1);
         if (w_inc_bad && (r_cnt_bad != '1)) r_cnt_bad <= r_cnt_bad + CNT_W'(1);
         if (w_inc_to  && (r_cnt_to  != '1)) r_cnt_to  <= r_cnt_to  + CNT_W'(1);
      end
   end

   // frame storage needs no reset; occupancy alone decides what is valid
   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_wr_ptr] <= {in_opt, in_len, in_data};
   end

   assign o_opt        = r_opt;
   assign o_len        = r_len;
   assign o_data       = r_data;
   assign o_valid      = r_valid;
   assign o_busy       = r_busy;
   assign cnt_overflow = r_cnt_ovf;
   assign cnt_bad_opt  = r_cnt_bad;
   assign cnt_timeout  = r_cnt_to;

endmodule

// File: tb/tb_uart_rx_frame_dispatcher.sv
// Bench for uart_rx_frame_dispatcher: queue-based reference model, delivery scoreboard,
// directed scenarios and a randomized traffic phase.
module tb_uart_rx_frame_dispatcher;

   localparam int unsigned BS    = 8;
   localparam int unsigned DS    = 64;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned ND    = 4;
   localparam int unsigned TO    = 8;
   localparam int unsigned CW    = 2;
   localparam int          CMAX  = 3;

   logic          CLK      = 1'b0;
   logic          RST_N    = 1'b1;
   logic [BS-1:0] in_opt   = '0;
   logic [BS-1:0] in_len   = '0;
   logic [DS-1:0] in_data  = '0;
   logic          in_valid = 1'b0;
   logic [ND-1:0] i_ready  = '0;
   logic [BS-1:0] o_opt, o_len;
   logic [DS-1:0] o_data;
   logic [ND-1:0] o_valid;
   logic          o_busy;
   logic [CW-1:0] cnt_overflow, cnt_bad_opt, cnt_timeout;

   uart_rx_frame_dispatcher #(
      .BYTE_SIZE(BS), .DATA_SIZE(DS), .DEPTH(DEPTH),
      .NUM_DEST(ND), .TIMEOUT(TO), .CNT_W(CW)
   ) dut (
      .CLK(CLK), .RST_N(RST_N),
      .in_opt(in_opt), .in_len(in_len), .in_data(in_data), .in_valid(in_valid),
      .o_opt(o_opt), .o_len(o_len), .o_data(o_data), .o_valid(o_valid),
      .i_ready(i_ready), .o_busy(o_busy),
      .cnt_overflow(cnt_overflow), .cnt_bad_opt(cnt_bad_opt), .cnt_timeout(cnt_timeout)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [BS-1:0] opt;
      logic [BS-1:0] len;
      logic [DS-1:0] data;
   } frame_t;

   int n_cmp = 0;
   int n_err = 0;
   int n_deliv = 0;

   task automatic chk(input string nm, input logic [DS-1:0] act, input logic [DS-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (evaluated mid-cycle) ----------------
   frame_t mq[$];
   frame_t exp_q[$];
   frame_t m_slot, m_shown, fr;
   bit     m_has;
   int     m_age;         // 0: frame just popped, k>=1: k-th cycle of being offered
   int     m_ovf, m_bad, m_to;
   int     occ0;
   bit     had;
   logic [ND-1:0] e_valid;
   bit     e_busy;
   frame_t e_shown;
   int     e_ovf, e_bad, e_to;

   always @(negedge CLK) begin
      if (!RST_N) begin
         mq.delete();
         exp_q.delete();
         m_has   = 1'b0;
         m_age   = 0;
         m_shown = '{8'h0, 8'h0, 64'h0};
         m_slot  = '{8'h0, 8'h0, 64'h0};
         m_ovf   = 0;
         m_bad   = 0;
         m_to    = 0;
      end
      e_valid = (m_has && m_age >= 1) ? (ND'(1) << m_slot.opt[1:0]) : '0;
      e_busy  = (mq.size() != 0) || m_has;
      e_shown = m_shown;
      e_ovf   = m_ovf;
      e_bad   = m_bad;
      e_to    = m_to;
      if (RST_N) begin
         occ0 = mq.size();
         had  = m_has;
         if (m_has) begin
            if (m_age == 0) begin
               if (int'(m_slot.opt) >= int'(ND)) begin
                  if (m_bad < CMAX) m_bad++;
                  m_has = 1'b0;
               end else m_age = 1;
            end else if (i_ready[m_slot.opt[1:0]]) begin
               exp_q.push_back(m_slot);
               m_has = 1'b0;
            end else if (m_age == int'(TO)) begin
               if (m_to < CMAX) m_to++;
               m_has = 1'b0;
            end else m_age++;
         end
         if (!had && mq.size() != 0) begin
            m_slot  = mq.pop_front();
            m_has   = 1'b1;
            m_age   = 0;
            m_shown = m_slot;
         end
         if (in_valid) begin
            if (occ0 == int'(DEPTH)) begin
               if (m_ovf < CMAX) m_ovf++;
            end else begin
               fr.opt  = in_opt;
               fr.len  = in_len;
               fr.data = in_data;
               mq.push_back(fr);
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic [BS-1:0] seen_len[$];
   logic [ND-1:0] seen_vld[$];
   frame_t        df;

   always begin
      @(negedge CLK);
      #1;
      chk("valid", DS'(o_valid), DS'(e_valid));
      chk("busy", DS'(o_busy), DS'(e_busy));
      chk("opt", DS'(o_opt), DS'(e_shown.opt));
      chk("len", DS'(o_len), DS'(e_shown.len));
      chk("data", o_data, e_shown.data);
      chk("cnt_overflow", DS'(cnt_overflow), DS'(e_ovf));
      chk("cnt_bad_opt", DS'(cnt_bad_opt), DS'(e_bad));
      chk("cnt_timeout", DS'(cnt_timeout), DS'(e_to));
      if (|(o_valid & i_ready)) begin
         n_deliv++;
         seen_len.push_back(o_len);
         seen_vld.push_back(o_valid);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL deliver: got opt %0h len %0h, expected no delivery at %0t", o_opt, o_len, $time);
         end else begin
            df = exp_q.pop_front();
            chk("dlv_opt", DS'(o_opt), DS'(df.opt));
            chk("dlv_len", DS'(o_len), DS'(df.len));
            chk("dlv_data", o_data, df.data);
            chk("dlv_onehot", DS'(o_valid), DS'(ND'(1) << df.opt[1:0]));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic v, input logic [BS-1:0] op, input logic [BS-1:0] ln,
                       input logic [DS-1:0] dt, input logic [ND-1:0] rdy);
      in_valid = v;
      in_opt   = op;
      in_len   = ln;
      in_data  = dt;
      i_ready  = rdy;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n, input logic [ND-1:0] rdy);
      repeat (n) step(1'b0, '0, '0, '0, rdy);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      i_ready  = '0;
      RST_N    = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
      seen_len.delete();
      seen_vld.delete();
   endtask

   int base, cnt;
   logic [BS-1:0] lv;
   logic [ND-1:0] vv;

   initial begin
      #1 RST_N = 1'b0;
      @(posedge CLK);
      #1;
      do_reset();
      chk("reset_valid", DS'(o_valid), '0);
      chk("reset_busy", DS'(o_busy), '0);

      // single frame, ready held high
      base = n_deliv;
      step(1'b1, 8'd2, 8'd3, 64'h0000_0000_00AA_BBCC, 4'b1111);
      idle(2, 4'b1111);
      chk("t1_valid", DS'(o_valid), DS'(4'b0100));
      chk("t1_opt", DS'(o_opt), 64'd2);
      chk("t1_len", DS'(o_len), 64'd3);
      chk("t1_data", o_data, 64'h0000_0000_00AA_BBCC);
      idle(1, 4'b1111);
      chk("t1_valid_after", DS'(o_valid), '0);
      chk("t1_busy_after", DS'(o_busy), '0);
      chk("t1_delivered", DS'(n_deliv - base), 64'd1);
      chk("t1_counters", DS'({cnt_overflow, cnt_bad_opt, cnt_timeout}), '0);

      // overflow with all consumers stalled, then drain
      do_reset();
      base = n_deliv;
      for (int i = 0; i < 6; i++)
         step(1'b1, 8'(i % 4), 8'(i), (64'(i) << 8) | 64'h5A, 4'b0000);
      chk("t2_overflow", DS'(cnt_overflow), 64'd1);
      idle(30, 4'b1111);
      chk("t2_delivered", DS'(n_deliv - base), 64'd5);
      for (int i = 0; i < 5; i++) begin
         lv = (seen_len.size() > i) ? seen_len[i] : 8'hFF;
         chk("t2_order", DS'(lv), DS'(i));
      end

      // unroutable opt followed by a good one
      do_reset();
      base = n_deliv;
      step(1'b1, 8'd9, 8'd1, 64'h99, 4'b1111);
      step(1'b1, 8'd1, 8'd2, 64'h11, 4'b1111);
      idle(10, 4'b1111);
      chk("t3_bad_opt", DS'(cnt_bad_opt), 64'd1);
      chk("t3_delivered", DS'(n_deliv - base), 64'd1);
      vv = (seen_vld.size() > 0) ? seen_vld[0] : '0;
      chk("t3_onehot", DS'(vv), DS'(4'b0010));

      // timeout, then ready arriving in the last offer cycle
      do_reset();
      base = n_deliv;
      cnt  = 0;
      step(1'b1, 8'd0, 8'd4, 64'h1234, 4'b0000);
      for (int i = 0; i < 14; i++) begin
         step(1'b0, '0, '0, '0, 4'b0000);
         if (o_valid[0]) cnt++;
      end
      chk("t4_offer_cycles", DS'(cnt), 64'd8);
      chk("t4_timeout", DS'(cnt_timeout), 64'd1);
      chk("t4_busy", DS'(o_busy), '0);
      step(1'b1, 8'd0, 8'd5, 64'h5678, 4'b0000);
      idle(9, 4'b0000);
      idle(1, 4'b0001);
      idle(3, 4'b0000);
      chk("t4_late_ready_timeout", DS'(cnt_timeout), 64'd1);
      chk("t4_late_ready_delivered", DS'(n_deliv - base), 64'd1);

      // saturation of a 2-bit counter
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'(9 + i), 8'(i), 64'(i), 4'b1111);
         idle(2, 4'b1111);
      end
      idle(4, 4'b1111);
      chk("t5_saturate", DS'(cnt_bad_opt), 64'd3);
      idle(10, 4'b1111);
      chk("t5_hold", DS'(cnt_bad_opt), 64'd3);

      // asynchronous reset while one frame is offered and three are buffered
      do_reset();
      step(1'b1, 8'd9, 8'd0, 64'h0, 4'b0000);
      idle(3, 4'b0000);
      for (int i = 0; i < 4; i++)
         step(1'b1, 8'(i), 8'(16 + i), 64'(i), 4'b0000);
      idle(1, 4'b0000);
      chk("t6_pre_valid", DS'(o_valid), DS'(4'b0001));
      chk("t6_pre_bad", DS'(cnt_bad_opt), 64'd1);
      #2 RST_N = 1'b0;
      #1;
      chk("t6_rst_valid", DS'(o_valid), '0);
      chk("t6_rst_busy", DS'(o_busy), '0);
      chk("t6_rst_counters", DS'({cnt_overflow, cnt_bad_opt, cnt_timeout}), '0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      base = n_deliv;
      idle(15, 4'b1111);
      chk("t6_no_stale", DS'(n_deliv - base), '0);
      chk("t6_busy", DS'(o_busy), '0);

      // randomized traffic against the model
      do_reset();
      repeat (400)
         step(($urandom_range(0, 9) < 4), 8'($urandom_range(0, 5)), 8'($urandom),
              {$urandom, $urandom}, 4'($urandom));
      idle(30, 4'b1111);
      chk("rand_drained", DS'(exp_q.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
